apb_timer: RTL and testbench
============================

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; only 32 is supported.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_2000, 32-byte-aligned register window base.
REQ-004 SHALL have ports: clk input 1, the single clock; rts input 1, asynchronous active-high reset.
REQ-005 SHALL have ports: APB_paddr input ADDR_WIDTH; APB_pdata input 32, write data; APB_prdata output 32, read data.
REQ-006 SHALL have ports: APB_psel input 1; APB_penable input 1; APB_pwrite input 1; APB_pstb input 4, write byte strobes.
REQ-007 SHALL have ports: APB_pready output 1; APB_perr output 1; irq output 1, level interrupt to the CPU interrupt input.

Function
REQ-008 SHALL decode the register map at offsets 0x00 CTRL, 0x04 COUNT, 0x08 COMPARE, 0x0C STATUS and 0x10 PRESCALE.
REQ-009 SHALL use CTRL bit0 as enable, bit1 as irq_en and bit2 as auto_reload; CTRL bits 31:3 SHALL read as 0.
REQ-010 SHALL use STATUS bit0 as pending (write-1-to-clear); STATUS bits 31:1 SHALL read as 0.
REQ-011 SHALL implement PRESCALE as 16 bits; bits 31:16 SHALL read as 0 and ignore writes.
REQ-012 SHALL track a transfer FSM with states IDLE, SETUP, WAIT and RESP.
REQ-013 FSM: IDLE->SETUP on psel&!penable; SETUP->WAIT if APB_TIMER_WAIT_EN is defined, else SETUP->RESP; WAIT->RESP after 1 cycle; RESP->IDLE (or ->SETUP if psel&!penable).
REQ-014 SHALL return the FSM to IDLE from any state when psel=0.
REQ-015 SHALL drive APB_pready = (state==RESP)&psel&penable; APB_pready SHALL be 0 otherwise.
REQ-016 SHALL drive APB_perr only together with pready, when the address is outside [BASE_ADDR, BASE_ADDR+0x13] or paddr[1:0]!=0.
REQ-017 SHALL drive APB_prdata combinationally with the addressed register when pready&!pwrite&!perr, and 0 otherwise.
REQ-018 SHALL commit a write on the rising edge where psel&penable&pready&pwrite&!perr, byte lanes gated by pstb[i]; erroring writes SHALL change no state.
REQ-019 Prescaler: while enable=1, presc_cnt SHALL increment each clk; when presc_cnt==PRESCALE, it SHALL reload to 0 and emit a 1-cycle tick.
REQ-020 SHALL increment COUNT by 1 on each tick, wrapping 0xFFFF_FFFF->0.
REQ-021 On a tick with COUNT==COMPARE, SHALL set pending and, if auto_reload=1, load COUNT with 0 instead of incrementing.
REQ-022 While enable=0, presc_cnt and COUNT SHALL hold; writing enable 0->1 SHALL clear presc_cnt.
REQ-023 A committed APB write to COUNT SHALL take priority over a same-cycle tick increment or reload.
REQ-024 A same-cycle pending set and W1C clear SHALL leave pending=1.
REQ-025 SHALL drive irq = pending & irq_en, registered-free (combinational from state).

Reset
REQ-026 Asserting rts SHALL immediately clear CTRL, COUNT, STATUS and presc_cnt, set COMPARE to 0xFFFF_FFFF and PRESCALE to 0, and force the FSM to IDLE.
REQ-027 During reset, APB_pready, APB_perr, APB_prdata and irq SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL abort it without a register update; the master SHALL restart it with a new SETUP phase.

Configuration
REQ-029 With macro APB_TIMER_WAIT_EN defined, every transfer SHALL have exactly one wait state, so pready rises on the 2nd access-phase cycle.
REQ-030 Without APB_TIMER_WAIT_EN, pready SHALL be high on the 1st access-phase cycle (zero wait).
REQ-031 Register behaviour SHALL be identical in both configurations.

Verification
REQ-032 Write PRESCALE=3, COMPARE=5, then CTRL=0x3 -> pending and irq rise exactly 24 clk after the CTRL write commit; COUNT reads 6.
REQ-033 Same setup with CTRL=0x7 -> COUNT reads 0 after the match tick, and pending repeats every 24 clk.
REQ-034 Write COUNT=0xFFFF_FFFF with PRESCALE=0, enable=1 -> next tick COUNT=0; a COUNT write coinciding with a tick yields the written value.
REQ-035 Read offset 0x14, then a write to 0x06 -> pready=1 with perr=1, prdata=0, no register change; pstb=4'b0010 write of 0xAABBCCDD to COMPARE -> COMPARE=0xFFFFCCFF.
REQ-036 Cover both APB_TIMER_WAIT_EN builds -> pready latency of 1 vs 0 access-phase wait cycles; W1C of STATUS on a same-cycle match keeps pending=1.
REQ-037 Assert rts during the WAIT state of a COMPARE write -> COMPARE=0xFFFF_FFFF, irq=0 and FSM in IDLE on release.

Source files
------------

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit counter with compare match, auto-reload and level irq.
// Define APB_TIMER_WAIT_EN to insert exactly one wait state into every APB transfer.
`timescale 1ns/1ps
module apb_timer #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_2000
) (
   input  logic                  clk,
   input  logic                  rts,
   input  logic [ADDR_WIDTH-1:0] APB_paddr,
   input  logic [DATA_WIDTH-1:0] APB_pdata,
   output logic [DATA_WIDTH-1:0] APB_prdata,
   input  logic                  APB_psel,
   input  logic                  APB_penable,
   input  logic                  APB_pwrite,
   input  logic [3:0]            APB_pstb,
   output logic                  APB_pready,
   output logic                  APB_perr,
   output logic                  irq,
   output logic [1:0]            dbg_state
);

   // APB handshake: a transfer is a setup cycle (psel & !penable) followed by
   // access cycles (psel & penable) until APB_pready=1; the write commits and
   // read data is valid on that last cycle, with APB_perr flagging a bad address.
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   state_t state;
   state_t phase;

   logic [2:0]  ctrl;
   logic [31:0] count;
   logic [31:0] compare;
   logic        pending;
   logic [15:0] prescale;
   logic [15:0] presc_cnt;

   logic [ADDR_WIDTH-1:0] off;
   logic        addr_ok;
   logic [2:0]  sel;
   logic        wr;
   logic        tick;
   logic        match;
   logic        w1c;
   logic [31:0] rdata;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] stb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = stb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   // The setup cycle is recognised as it happens, so the registered state can
   // already be RESP on the first access cycle in the zero-wait build.
   always_comb begin
      phase = state;
      if (!APB_psel)
         phase = IDLE;
      else if (!APB_penable && (state == IDLE || state == RESP))
         phase = SETUP;
   end

   always_ff @(posedge clk or posedge rts) begin
      if (rts) begin
         state <= IDLE;
      end else begin
         case (phase)
`ifdef APB_TIMER_WAIT_EN
            SETUP:   state <= WAIT;
`else
            SETUP:   state <= RESP;
`endif
            WAIT:    state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = phase;

   // Base is 32-byte aligned, so the low offset bits equal the low address bits.
   assign off     = APB_paddr - BASE;
   assign addr_ok = (APB_paddr >= BASE) && (off <= ADDR_WIDTH'(32'h13)) && (off[1:0] == 2'b00);
   assign sel     = off[4:2];

   assign APB_pready = (state == RESP) && APB_psel && APB_penable;
   assign APB_perr   = APB_pready && !addr_ok;
   assign wr         = APB_pready && APB_pwrite && !APB_perr;

   assign tick  = ctrl[0] && (presc_cnt == prescale);
   assign match = tick && (count == compare);
   assign w1c   = wr && (sel == 3'd3) && APB_pstb[0] && APB_pdata[0];

   always_ff @(posedge clk or posedge rts) begin
      if (rts) begin
         ctrl      <= 3'b000;
         count     <= 32'h0;
         compare   <= 32'hFFFF_FFFF;
         pending   <= 1'b0;
         prescale  <= 16'h0;
         presc_cnt <= 16'h0;
      end else begin
         if (wr && sel == 3'd0 && APB_pstb[0])
            ctrl <= APB_pdata[2:0];
         if (wr && sel == 3'd2)
            compare <= merge(compare, APB_pdata, APB_pstb);
         if (wr && sel == 3'd4) begin
            if (APB_pstb[0]) prescale[7:0]  <= APB_pdata[7:0];
            if (APB_pstb[1]) prescale[15:8] <= APB_pdata[15:8];
         end

         // Turning the timer on starts a fresh prescale period.
         if (wr && sel == 3'd0 && APB_pstb[0] && !ctrl[0] && APB_pdata[0])
            presc_cnt <= 16'h0;
         else if (tick)
            presc_cnt <= 16'h0;
         else if (ctrl[0])
            presc_cnt <= presc_cnt + 16'h1;

         if (wr && sel == 3'd1)
            count <= merge(count, APB_pdata, APB_pstb);
         else if (tick)
            count <= (match && ctrl[2]) ? 32'h0 : count + 32'h1;

         pending <= match ? 1'b1 : (w1c ? 1'b0 : pending);
      end
   end

   always_comb begin
      case (sel)
         3'd0:    rdata = {29'h0, ctrl};
         3'd1:    rdata = count;
         3'd2:    rdata = compare;
         3'd3:    rdata = {31'h0, pending};
         3'd4:    rdata = {16'h0, prescale};
         default: rdata = 32'h0;
      endcase
   end

   assign APB_prdata = (APB_pready && !APB_pwrite && !APB_perr) ? rdata : 32'h0;
   assign irq        = pending && ctrl[1];

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: register map, error responses, timer timing and reset abort.
`timescale 1ns/1ps
module tb_apb_timer;
  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef APB_TIMER_WAIT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rts;
  logic [31:0] paddr, pdata, prdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstb;
  logic        pready, perr, irq;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rts(rts),
    .APB_paddr(paddr), .APB_pdata(pdata), .APB_prdata(prdata),
    .APB_psel(psel), .APB_penable(penable), .APB_pwrite(pwrite), .APB_pstb(pstb),
    .APB_pready(pready), .APB_perr(perr), .irq(irq), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rts = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pdata = 32'h0; pstb = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rts = 1'b0;
  endtask

  // driver tasks
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] stb, output logic [31:0] rd, output logic err,
                          output int lat);
    logic rdy;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = data; pstb = stb;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; rdy = 1'b0; rd = 32'h0; err = 1'b0;
    for (int k = 0; k < 8 && !rdy; k++) begin
      @(negedge clk);
      if (pready) begin
        rdy = 1'b1; rd = prdata; err = perr;
      end else begin
        lat++;
        @(posedge clk); #1;
      end
    end
    if (!rdy) begin
      n_checks++;
      $display("FAIL pready_timeout: no pready after %0d cycles, required within 8", lat);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] data, input logic [3:0] stb);
    logic [31:0] d; logic e; int l;
    apb_xfer(1'b1, BASE + off, data, stb, d, e, l);
  endtask

  task automatic rd_reg(input logic [31:0] off, output logic [31:0] data);
    logic e; int l;
    apb_xfer(1'b0, BASE + off, 32'h0, 4'h0, data, e, l);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          l;
    int          n;

    // outputs stay quiet under reset even with an access phase on the bus
    rts = 1'b1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    paddr = BASE; pdata = 32'h0; pstb = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rts = 1'b0;

    // scoreboard: reset values of CTRL, COUNT, COMPARE, STATUS, PRESCALE
    exp_q = {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      apb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, d, e, l);
      check($sformatf("rst_reg%0d", i), d, exp_q.pop_front());
      if (i == 0) begin
        check("read_latency", 32'(l), 32'(LAT));
        check("good_read_perr", 32'(e), 32'd0);
      end
    end

    // error responses and byte strobes
    apb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, d, e, l);
    check("rd14_perr", 32'(e), 32'd1);
    check("rd14_prdata", d, 32'h0);
    apb_xfer(1'b1, BASE + 32'h06, 32'h1234_5678, 4'hF, d, e, l);
    check("wr06_perr", 32'(e), 32'd1);
    apb_xfer(1'b0, BASE - 32'h4, 32'h0, 4'h0, d, e, l);
    check("rd_below_perr", 32'(e), 32'd1);
    apb_xfer(1'b1, BASE + 32'h09, 32'h0, 4'hF, d, e, l);
    check("wr09_perr", 32'(e), 32'd1);
    rd_reg(32'h04, d);
    check("count_after_err", d, 32'h0);
    rd_reg(32'h08, d);
    check("compare_after_err", d, 32'hFFFF_FFFF);
    wr_reg(32'h08, 32'hAABB_CCDD, 4'b0010);
    rd_reg(32'h08, d);
    check("compare_lane1", d, 32'hFFFF_CCFF);
    wr_reg(32'h00, 32'hFFFF_FFF8, 4'hF);
    rd_reg(32'h00, d);
    check("ctrl_upper_zero", d, 32'h0);
    wr_reg(32'h10, 32'hFFFF_FFFF, 4'hF);
    rd_reg(32'h10, d);
    check("prescale_16b", d, 32'h0000_FFFF);

    // one-shot match: tick every 4 clk, pending on 6th tick
    do_reset();
    wr_reg(32'h10, 32'd3, 4'hF);
    wr_reg(32'h08, 32'd5, 4'hF);
    wr_reg(32'h00, 32'h3, 4'hF);
    wait_irq(n);
    check("irq_rise_oneshot", 32'(n), 32'd24);
    rd_reg(32'h04, d);
    check("count_oneshot", d, 32'd6);
    rd_reg(32'h0C, d);
    check("status_oneshot", d, 32'd1);
    wr_reg(32'h00, 32'h1, 4'hF);
    check("irq_masked", 32'(irq), 32'd0);

    // auto-reload: COUNT returns to 0, pending repeats every 24 clk
    do_reset();
    wr_reg(32'h10, 32'd3, 4'hF);
    wr_reg(32'h08, 32'd5, 4'hF);
    wr_reg(32'h00, 32'h7, 4'hF);
    wait_irq(n);
    check("irq_rise_reload", 32'(n), 32'd24);
    rd_reg(32'h04, d);
    check("count_reloaded", d, 32'd0);
    wr_reg(32'h0C, 32'h1, 4'h1);
    check("irq_after_w1c", 32'(irq), 32'd0);
    // the read and W1C above consume 6 + 2*LAT of the 24 clk period
    wait_irq(n);
    check("irq_repeat", 32'(n), 32'(24 - (6 + 2 * LAT)));

    // wrap: FFFF_FFFF -> 0 on the 8th clk, matching the reset COMPARE
    do_reset();
    wr_reg(32'h10, 32'd7, 4'hF);
    wr_reg(32'h04, 32'hFFFF_FFFF, 4'hF);
    wr_reg(32'h00, 32'h1, 4'hF);
    repeat (8) @(posedge clk);
    #1;
    rd_reg(32'h04, d);
    check("count_wrap", d, 32'h0);
    rd_reg(32'h0C, d);
    check("status_wrap", d, 32'd1);

    // COUNT write wins over a same-cycle tick; disabled timer holds
    do_reset();
    wr_reg(32'h00, 32'h1, 4'hF);
    wr_reg(32'h04, 32'h0000_1234, 4'hF);
    wr_reg(32'h00, 32'h0, 4'hF);
    rd_reg(32'h04, d);
    check("count_write_prio", d, 32'h0000_1234 + 32'(3 + LAT));
    repeat (5) @(posedge clk);
    rd_reg(32'h04, d);
    check("count_hold", d, 32'h0000_1234 + 32'(3 + LAT));

    // W1C commit on the match edge keeps pending set
    do_reset();
    wr_reg(32'h08, 32'(2 + LAT), 4'hF);
    wr_reg(32'h00, 32'h1, 4'hF);
    wr_reg(32'h0C, 32'h1, 4'h1);
    rd_reg(32'h0C, d);
    check("w1c_vs_set", d, 32'd1);
    wr_reg(32'h0C, 32'h1, 4'h1);
    rd_reg(32'h0C, d);
    check("w1c_clear", d, 32'd0);

    // reset in the middle of a COMPARE write aborts it
    do_reset();
    wr_reg(32'h08, 32'h0, 4'hF);
    wr_reg(32'h00, 32'h3, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check("irq_pre_abort", 32'(irq), 32'd1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = BASE + 32'h08; pdata = 32'h0000_0055; pstb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rts = 1'b1;
    #1;
    check("abort_pready", 32'(pready), 32'd0);
    check("abort_irq", 32'(irq), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rts = 1'b0;
    #1;
    check("abort_state_idle", 32'(dbg_state), 32'd0);
    check("abort_pready_rel", 32'(pready), 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd_reg(32'h08, d);
    check("abort_compare", d, 32'hFFFF_FFFF);
    rd_reg(32'h00, d);
    check("abort_ctrl", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
